// File: rtl/usb_hub_repeater.sv
// Packet-level hub repeater: broadcasts host bytes downstream, locks
// the first responding port upstream, with timeout and babble lockout.
module usb_hub_repeater #(
  parameter int NUM_USB_DEVICES = 16,
  parameter int DATA_W = 8,
  parameter int MAX_PKT_BYTES = 1027,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int PW = $clog2(NUM_USB_DEVICES),
  localparam int CW = $clog2(MAX_PKT_BYTES + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                              hi_clock,
  input  logic                              reset,
  input  logic [NUM_USB_DEVICES-1:0]        port_enable,
  input  logic [NUM_USB_DEVICES-1:0]        babble_clear,
  input  logic                              us_rx_valid,
  input  logic [DATA_W-1:0]                 us_rx_data,
  input  logic                              us_rx_last,
  output logic [NUM_USB_DEVICES-1:0]        ds_tx_valid,
  output logic [DATA_W-1:0]                 ds_tx_data,
  output logic                              ds_tx_last,
  input  logic [NUM_USB_DEVICES-1:0]        ds_rx_valid,
  input  logic [NUM_USB_DEVICES*DATA_W-1:0] ds_rx_data,
  input  logic [NUM_USB_DEVICES-1:0]        ds_rx_last,
  output logic                              us_tx_valid,
  output logic [DATA_W-1:0]                 us_tx_data,
  output logic                              us_tx_last,
  output logic [PW-1:0]                     active_port,
  output logic [1:0]                        rep_state,
  output logic [NUM_USB_DEVICES-1:0]        babble_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DOWN      = 2'd1,
    WAIT_RESP = 2'd2,
    UP        = 2'd3
  } state_t;

  state_t state, state_n;
  logic [PW-1:0] ap_n, pick;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [NUM_USB_DEVICES-1:0] eff_en, req, set_mask;
  logic [NUM_USB_DEVICES-1:0] dv_n;
  logic [DATA_W-1:0] dd_n, ud_n;
  logic dl_n, uv_n, ul_n;
  logic [DATA_W-1:0] rx_byte [NUM_USB_DEVICES];

  always_comb begin
    for (int i = 0; i < NUM_USB_DEVICES; i++)
      rx_byte[i] = ds_rx_data[i*DATA_W +: DATA_W];
  end

  // Lowest-index enabled responder wins arbitration
  always_comb begin
    eff_en = port_enable & ~babble_err;
    req = ds_rx_valid & eff_en;
    pick = '0;
    for (int i = NUM_USB_DEVICES - 1; i >= 0; i--)
      if (req[i]) pick = PW'(i);
  end

  always_comb begin
    state_n = state;
    ap_n = active_port;
    cnt_n = cnt;
    tmr_n = tmr;
    set_mask = '0;
    dv_n = '0;
    dd_n = '0;
    dl_n = 1'b0;
    uv_n = 1'b0;
    ud_n = '0;
    ul_n = 1'b0;
    unique case (state)
      IDLE, DOWN, WAIT_RESP: begin
        if (state == WAIT_RESP && tmr != TW'(TIMEOUT_CYCLES))
          tmr_n = tmr + TW'(1);
        if (us_rx_valid) begin
          dv_n = eff_en;
          dd_n = us_rx_data;
          dl_n = us_rx_last;
          state_n = us_rx_last ? WAIT_RESP : DOWN;
          if (us_rx_last) tmr_n = '0;
        end else if (state == WAIT_RESP) begin
          if (|req) begin
            ap_n = pick;
            uv_n = 1'b1;
            ud_n = rx_byte[pick];
            cnt_n = CW'(1);
            ul_n = ds_rx_last[pick];
            state_n = ds_rx_last[pick] ? WAIT_RESP : UP;
            if (ds_rx_last[pick]) tmr_n = '0;
          end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
          end
        end
      end
      UP: begin
        if (!port_enable[active_port]) begin
          // Synthesize an end of packet so the host sees a closed frame
          uv_n = 1'b1;
          ul_n = 1'b1;
          state_n = IDLE;
        end else if (ds_rx_valid[active_port]) begin
          uv_n = 1'b1;
          ud_n = rx_byte[active_port];
          if (cnt != CW'(MAX_PKT_BYTES))
            cnt_n = cnt + CW'(1);
          if (ds_rx_last[active_port]) begin
            ul_n = 1'b1;
            state_n = WAIT_RESP;
            tmr_n = '0;
          end else if (cnt == CW'(MAX_PKT_BYTES - 1)) begin
            ul_n = 1'b1;
            set_mask[active_port] = 1'b1;
            state_n = WAIT_RESP;
            tmr_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hi_clock) begin
    if (reset) begin
      state <= IDLE;
      active_port <= '0;
      cnt <= '0;
      tmr <= '0;
      babble_err <= '0;
      ds_tx_valid <= '0;
      ds_tx_data <= '0;
      ds_tx_last <= 1'b0;
      us_tx_valid <= 1'b0;
      us_tx_data <= '0;
      us_tx_last <= 1'b0;
    end else begin
      state <= state_n;
      active_port <= ap_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      babble_err <= (babble_err & ~babble_clear) | set_mask;
      ds_tx_valid <= dv_n;
      ds_tx_data <= dd_n;
      ds_tx_last <= dl_n;
      us_tx_valid <= uv_n;
      us_tx_data <= ud_n;
      us_tx_last <= ul_n;
    end
  end

  assign rep_state = state;

endmodule

// File: tb/tb_usb_hub_repeater.sv
// Scoreboard bench for usb_hub_repeater: directed host/device traffic,
// expected bytes queued at issue time and checked by a monitor.
module tb_usb_hub_repeater;

  localparam int N = 16;
  localparam int W = 8;

  logic hi_clock = 1'b0;
  logic reset;
  logic [N-1:0] port_enable, babble_clear;
  logic us_rx_valid, us_rx_last;
  logic [W-1:0] us_rx_data;
  logic [N-1:0] ds_tx_valid;
  logic [W-1:0] ds_tx_data;
  logic ds_tx_last;
  logic [N-1:0] ds_rx_valid, ds_rx_last;
  logic [N*W-1:0] ds_rx_data;
  logic us_tx_valid, us_tx_last;
  logic [W-1:0] us_tx_data;
  logic [3:0] active_port;
  logic [1:0] rep_state;
  logic [N-1:0] babble_err;

  usb_hub_repeater #(
    .NUM_USB_DEVICES(N),
    .DATA_W(W),
    .MAX_PKT_BYTES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .hi_clock(hi_clock),
    .reset(reset),
    .port_enable(port_enable),
    .babble_clear(babble_clear),
    .us_rx_valid(us_rx_valid),
    .us_rx_data(us_rx_data),
    .us_rx_last(us_rx_last),
    .ds_tx_valid(ds_tx_valid),
    .ds_tx_data(ds_tx_data),
    .ds_tx_last(ds_tx_last),
    .ds_rx_valid(ds_rx_valid),
    .ds_rx_data(ds_rx_data),
    .ds_rx_last(ds_rx_last),
    .us_tx_valid(us_tx_valid),
    .us_tx_data(us_tx_data),
    .us_tx_last(us_tx_last),
    .active_port(active_port),
    .rep_state(rep_state),
    .babble_err(babble_err)
  );

  always #5 hi_clock = ~hi_clock;

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] d;
    logic l;
  } ds_exp_t;

  typedef struct {
    logic [W-1:0] d;
    logic l;
  } us_exp_t;

  ds_exp_t ds_q[$];
  us_exp_t us_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hi_clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic host(input logic [W-1:0] d, input logic l,
                      input logic [N-1:0] mask);
    ds_exp_t e;
    us_rx_valid = 1'b1;
    us_rx_data = d;
    us_rx_last = l;
    e.v = mask;
    e.d = d;
    e.l = l;
    ds_q.push_back(e);
    cyc();
    us_rx_valid = 1'b0;
    us_rx_last = 1'b0;
    us_rx_data = '0;
  endtask

  task automatic dev(input int p, input logic [W-1:0] d, input logic l);
    ds_rx_valid[p] = 1'b1;
    ds_rx_data[p*W +: W] = d;
    ds_rx_last[p] = l;
  endtask

  task automatic dev_clr();
    ds_rx_valid = '0;
    ds_rx_last = '0;
    ds_rx_data = '0;
  endtask

  task automatic exp_up(input logic [W-1:0] d, input logic l);
    us_exp_t e;
    e.d = d;
    e.l = l;
    us_q.push_back(e);
  endtask

  // Monitor: every presented output byte must match the next queued one
  initial begin
    forever begin
      @(negedge hi_clock);
      if (ds_tx_valid != '0 || ds_tx_last) begin
        if (ds_q.size() == 0) begin
          chk("ds_unexpected", {15'd0, ds_tx_last, ds_tx_valid}, 32'd0);
        end else begin
          ds_exp_t e;
          e = ds_q.pop_front();
          chk("ds_valid", 32'(ds_tx_valid), 32'(e.v));
          chk("ds_data", 32'(ds_tx_data), 32'(e.d));
          chk("ds_last", 32'(ds_tx_last), 32'(e.l));
        end
      end
      if (us_tx_valid || us_tx_last) begin
        if (us_q.size() == 0) begin
          chk("us_unexpected", {23'd0, us_tx_last, us_tx_data}, 32'd0);
        end else begin
          us_exp_t e;
          e = us_q.pop_front();
          chk("us_data", 32'(us_tx_data), 32'(e.d));
          chk("us_last", 32'(us_tx_last), 32'(e.l));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    port_enable = '0;
    babble_clear = '0;
    us_rx_valid = 1'b0;
    us_rx_data = '0;
    us_rx_last = 1'b0;
    dev_clr();
    idle(3);
    chk("rst_state", 32'(rep_state), 32'd0);
    chk("rst_port", 32'(active_port), 32'd0);
    chk("rst_babble", 32'(babble_err), 32'd0);
    chk("rst_usv", 32'(us_tx_valid), 32'd0);
    chk("rst_dsv", 32'(ds_tx_valid), 32'd0);
    reset = 1'b0;
    port_enable = 16'h00F5;
    idle(1);

    // Device traffic in IDLE is ignored
    dev(0, 8'hEE, 1'b1);
    cyc();
    dev_clr();
    chk("idle_ign_state", 32'(rep_state), 32'd0);

    // Broadcast
    host(8'h69, 1'b0, 16'h00F5);
    chk("bc_down", 32'(rep_state), 32'd1);
    host(8'h12, 1'b0, 16'h00F5);
    host(8'h34, 1'b1, 16'h00F5);
    chk("bc_wait", 32'(rep_state), 32'd2);

    // Arbitration: 2 beats 5
    dev(2, 8'hA1, 1'b0);
    dev(5, 8'hB1, 1'b0);
    exp_up(8'hA1, 1'b0);
    cyc();
    chk("arb_port", 32'(active_port), 32'd2);
    chk("arb_up", 32'(rep_state), 32'd3);
    dev(2, 8'hA2, 1'b1);
    dev(5, 8'hB2, 1'b1);
    exp_up(8'hA2, 1'b1);
    cyc();
    dev_clr();
    chk("arb_end", 32'(rep_state), 32'd2);

    // Timeout exactly 64 cycles after entry
    idle(63);
    chk("to_still_wait", 32'(rep_state), 32'd2);
    cyc();
    chk("to_idle", 32'(rep_state), 32'd0);

    // Late response at timer 62 still accepted
    host(8'h2D, 1'b1, 16'h00F5);
    idle(62);
    chk("late_wait", 32'(rep_state), 32'd2);
    dev(4, 8'hC4, 1'b1);
    exp_up(8'hC4, 1'b1);
    cyc();
    dev_clr();
    chk("late_port", 32'(active_port), 32'd4);
    chk("late_state", 32'(rep_state), 32'd2);

    // Babble on port 3
    port_enable = 16'h00FD;
    host(8'hE1, 1'b1, 16'h00FD);
    for (int i = 0; i < 6; i++) begin
      dev(3, 8'(8'h31 + i), 1'b0);
      if (i < 4) exp_up(8'(8'h31 + i), i == 3);
      cyc();
      if (i == 2) chk("bab_up", 32'(rep_state), 32'd3);
    end
    dev_clr();
    chk("bab_flag", 32'(babble_err), 32'h0008);
    chk("bab_state", 32'(rep_state), 32'd2);
    host(8'h55, 1'b1, 16'h00F5);
    babble_clear[3] = 1'b1;
    cyc();
    babble_clear = '0;
    chk("bab_clear", 32'(babble_err), 32'h0000);
    host(8'h66, 1'b1, 16'h00FD);

    // Disable mid-packet
    dev(6, 8'h61, 1'b0);
    exp_up(8'h61, 1'b0);
    cyc();
    chk("dis_port", 32'(active_port), 32'd6);
    port_enable = 16'h00BD;
    dev(6, 8'h62, 1'b0);
    exp_up(8'h00, 1'b1);
    cyc();
    dev_clr();
    chk("dis_idle", 32'(rep_state), 32'd0);
    port_enable = 16'h00FD;
    idle(1);

    // Reset during DOWN
    host(8'h77, 1'b0, 16'h00FD);
    chk("rm_down", 32'(rep_state), 32'd1);
    reset = 1'b1;
    us_rx_valid = 1'b1;
    us_rx_data = 8'h78;
    us_rx_last = 1'b1;
    cyc();
    us_rx_valid = 1'b0;
    us_rx_last = 1'b0;
    chk("rm_dsv", 32'(ds_tx_valid), 32'd0);
    chk("rm_dsl", 32'(ds_tx_last), 32'd0);
    chk("rm_dsd", 32'(ds_tx_data), 32'd0);
    chk("rm_usv", 32'(us_tx_valid), 32'd0);
    chk("rm_state", 32'(rep_state), 32'd0);
    reset = 1'b0;
    idle(3);

    chk("ds_q_empty", 32'(ds_q.size()), 32'd0);
    chk("us_q_empty", 32'(us_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
